// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher: widths, fetch state and buffer entry layout.
// The JAL helper is used only when FETCH_JAL_PREDECODE_EN is defined.
package inst_fetcher_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [6:0] OPC_JAL = 7'b1101111;

   typedef enum logic {
      FETCH = 1'b0,
      STALL = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } iq_entry_t;

   // J-type immediate is scattered across [31:12]; bit 0 is implicitly zero
   function automatic logic [XLEN-1:0] jal_target(input logic [XLEN-1:0] pc,
                                                  input logic [ILEN-1:0] instr);
      logic [XLEN-1:0] imm;
      imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      return pc + imm;
   endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Cache-fetch and decoder-feed signals of the instruction fetcher.
// master = fetcher side, slave = cache/decoder environment.
interface inst_fetcher_if;
   import inst_fetcher_pkg::*;

   logic            out_fetcher_ready;
   logic [XLEN-1:0] instr_addr;
   logic            cache_free;
   logic            in_cache_ready;
   logic [ILEN-1:0] cache_instr;
   logic [XLEN-1:0] cache_instr_addr;
   logic            dec_valid;
   logic [ILEN-1:0] dec_instr;
   logic [XLEN-1:0] dec_pc;
   logic            dec_ready;

   modport master (
      output out_fetcher_ready, instr_addr, dec_valid, dec_instr, dec_pc,
      input  cache_free, in_cache_ready, cache_instr, cache_instr_addr, dec_ready
   );

   modport slave (
      input  out_fetcher_ready, instr_addr, dec_valid, dec_instr, dec_pc,
      output cache_free, in_cache_ready, cache_instr, cache_instr_addr, dec_ready
   );

endinterface

// File: rtl/inst_fifo.sv
// Synchronous {pc, instr} FIFO with flush and a registered head entry (zero when empty).
// full_next reports occupancy after this cycle's push/pop so the fetcher can stall early.
module inst_fifo
   import inst_fetcher_pkg::*;
#(
   parameter int DEPTH_LOG = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               flush,
   input  logic               push,
   input  logic               pop,
   input  iq_entry_t          push_data,
   output iq_entry_t          head_data,
   output logic               head_valid,
   output logic               full,
   output logic               full_next,
   output logic               empty,
   output logic [DEPTH_LOG:0] count
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam int CW    = DEPTH_LOG + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   iq_entry_t            mem_r [DEPTH];
   logic [DEPTH_LOG-1:0] head_r, tail_r, head_s, tail_s;
   logic [CW-1:0]        count_r, count_s;
   iq_entry_t            head_data_r, head_data_s;
   logic                 head_valid_r;

   // Next pointers/occupancy and the entry that will sit at the head after this edge
   always_comb begin
      head_s      = head_r;
      tail_s      = tail_r;
      count_s     = count_r;
      head_data_s = '0;
      if (flush) begin
         head_s  = '0;
         tail_s  = '0;
         count_s = '0;
      end else begin
         if (pop) head_s = head_r + DEPTH_LOG'(1);
         else     head_s = head_r;
         if (push) tail_s = tail_r + DEPTH_LOG'(1);
         else      tail_s = tail_r;
         count_s = count_r + CW'(push) - CW'(pop);
      end
      // A push into an (about to be) empty buffer becomes the head directly
      if (count_s == '0)                   head_data_s = '0;
      else if (push && (head_s == tail_r)) head_data_s = push_data;
      else                                 head_data_s = mem_r[head_s];
   end

   // Pointer, occupancy and head-register update
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r       <= '0;
         tail_r       <= '0;
         count_r      <= '0;
         head_data_r  <= '0;
         head_valid_r <= 1'b0;
      end else if (en) begin
         head_r       <= head_s;
         tail_r       <= tail_s;
         count_r      <= count_s;
         head_data_r  <= head_data_s;
         head_valid_r <= (count_s != '0);
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      if (!rst && en && push && !flush) mem_r[tail_r] <= push_data;
   end

   assign head_data  = head_data_r;
   assign head_valid = head_valid_r;
   assign full       = (count_r == FULL_CNT);
   assign full_next  = (count_s == FULL_CNT);
   assign empty      = (count_r == '0);
   assign count      = count_r;

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetcher: holds the PC, requests words from the cache, buffers {instr, pc} for the decoder.
// Optional FETCH_JAL_PREDECODE_EN redirects the PC to a JAL target when the JAL is pushed.
module inst_fetcher
   import inst_fetcher_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
   parameter int              IQ_DEPTH_LOG = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              rob_clear,
   input  logic [XLEN-1:0]   rob_new_pc,
   inst_fetcher_if.master    bus
);

   fetch_state_e        state_r, state_s;
   logic [XLEN-1:0]     pc_r, pc_s, seq_pc_s;
   logic                req_r;
   logic [XLEN-1:0]     addr_r;
   logic                accept_s, pop_s;
   iq_entry_t           push_entry_s, head_entry_s;
   logic                head_valid_s, fifo_full_s, fifo_full_next_s, fifo_empty_s;
   logic [IQ_DEPTH_LOG:0] fifo_count_s;
   logic                unused_s;

   // Address following an accepted instruction
   always_comb begin
`ifdef FETCH_JAL_PREDECODE_EN
      if (bus.cache_instr[6:0] == OPC_JAL) seq_pc_s = jal_target(pc_r, bus.cache_instr);
      else                                 seq_pc_s = pc_r + 32'd4;
`else
      seq_pc_s = pc_r + 32'd4;
`endif
   end

   // Response acceptance, PC update and fetch/stall next state
   always_comb begin
      state_s  = state_r;
      pc_s     = pc_r;
      pop_s    = head_valid_s && !fifo_empty_s && bus.dec_ready;
      accept_s = (state_r == FETCH) && bus.in_cache_ready && !rob_clear &&
                 (bus.cache_instr_addr == pc_r) && !(fifo_full_s && !pop_s);
      if (rob_clear)     pc_s = rob_new_pc;
      else if (accept_s) pc_s = seq_pc_s;
      else               pc_s = pc_r;
      case (state_r)
         FETCH:   if (fifo_full_next_s) state_s = STALL; else state_s = FETCH;
         STALL:   if (fifo_full_next_s) state_s = STALL; else state_s = FETCH;
         default: state_s = FETCH;
      endcase
   end

   // State, PC and registered request outputs; rdy low freezes everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= FETCH;
         pc_r    <= RESET_PC;
         req_r   <= 1'b0;
         addr_r  <= RESET_PC;
      end else if (rdy) begin
         state_r <= state_s;
         pc_r    <= pc_s;
         req_r   <= (state_s == FETCH);
         addr_r  <= pc_s;
      end
   end

   assign push_entry_s = {pc_r, bus.cache_instr};

   inst_fifo #(
      .DEPTH_LOG (IQ_DEPTH_LOG)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .en         (rdy),
      .flush      (rob_clear),
      .push       (accept_s),
      .pop        (pop_s),
      .push_data  (push_entry_s),
      .head_data  (head_entry_s),
      .head_valid (head_valid_s),
      .full       (fifo_full_s),
      .full_next  (fifo_full_next_s),
      .empty      (fifo_empty_s),
      .count      (fifo_count_s)
   );

   assign bus.out_fetcher_ready = req_r;
   assign bus.instr_addr        = addr_r;
   assign bus.dec_valid         = head_valid_s;
   assign bus.dec_instr         = head_entry_s.instr;
   assign bus.dec_pc            = head_entry_s.pc;

   // cache_free is informational only
   assign unused_s = ^{bus.cache_free, fifo_count_s};

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: directed vector table, hand sequences and a randomized run
// against a queue-based reference model with a latency-randomized cache responder.
module tb_inst_fetcher;
   import inst_fetcher_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, rob_clear;
   logic [31:0] rob_new_pc;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   inst_fetcher_if bus();

   inst_fetcher #(.RESET_PC(32'h0000_0000), .IQ_DEPTH_LOG(2)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear), .rob_new_pc(rob_new_pc), .bus(bus)
   );

   // reference model: a queue of {pc, instr}, the pc and the request flag
   logic [63:0] mq[$];
   logic [31:0] m_pc;
   logic        m_req;
   // cache responder state
   logic        c_busy;
   int          c_cnt;
   logic [31:0] c_addr;

   typedef struct {
      logic rdy; logic clr; logic [31:0] npc;
      logic resp; logic [31:0] raddr; logic [31:0] rinstr; logic dready;
      logic [31:0] e_addr; logic e_req; logic e_valid; logic [31:0] e_pc; logic [31:0] e_instr;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t v(input logic rd, input logic cl, input logic [31:0] np,
                              input logic rs, input logic [31:0] ra, input logic [31:0] ri,
                              input logic dr, input logic [31:0] ea, input logic er,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ei);
      vec_t r;
      r.rdy = rd; r.clr = cl; r.npc = np; r.resp = rs; r.raddr = ra; r.rinstr = ri; r.dready = dr;
      r.e_addr = ea; r.e_req = er; r.e_valid = ev; r.e_pc = ep; r.e_instr = ei;
      return r;
   endfunction

   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] instr);
`ifdef FETCH_JAL_PREDECODE_EN
      logic [20:0] imm;
      int          off;
      imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      off = imm[20] ? (int'(imm) - (1 << 21)) : int'(imm);
      if (instr[6:0] == 7'b1101111) return pc + 32'(off);
`endif
      return pc + 32'd4 + (32'd0 & instr);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic i_rst, input logic i_rdy, input logic i_clr,
                             input logic [31:0] i_npc, input logic i_resp, input logic [31:0] i_raddr,
                             input logic [31:0] i_rinstr, input logic i_dready);
      logic do_pop, do_push;
      if (i_rst) begin
         mq.delete(); m_pc = 32'h0; m_req = 1'b0;
      end else if (i_rdy) begin
         if (i_clr) begin
            mq.delete(); m_pc = i_npc;
         end else begin
            do_pop  = (mq.size() > 0) && i_dready;
            do_push = (mq.size() < 4) && i_resp && (i_raddr == m_pc);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
               mq.push_back({m_pc, i_rinstr});
               m_pc = ref_next(m_pc, i_rinstr);
            end
         end
         m_req = (mq.size() < 4);
      end
   endtask

   task automatic compare_model();
      check("req",   32'(bus.out_fetcher_ready), 32'(m_req));
      check("addr",  bus.instr_addr, m_pc);
      check("valid", 32'(bus.dec_valid), 32'(mq.size() != 0));
      check("dinstr", bus.dec_instr, (mq.size() != 0) ? mq[0][31:0]  : 32'h0);
      check("dpc",    bus.dec_pc,    (mq.size() != 0) ? mq[0][63:32] : 32'h0);
   endtask

   task automatic drive(input logic i_rst, input logic i_rdy, input logic i_clr, input logic [31:0] i_npc,
                        input logic i_resp, input logic [31:0] i_raddr, input logic [31:0] i_rinstr,
                        input logic i_dready);
      rst = i_rst; rdy = i_rdy; rob_clear = i_clr; rob_new_pc = i_npc;
      bus.in_cache_ready = i_resp; bus.cache_instr_addr = i_raddr; bus.cache_instr = i_rinstr;
      bus.dec_ready = i_dready;
      model_step(i_rst, i_rdy, i_clr, i_npc, i_resp, i_raddr, i_rinstr, i_dready);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic i_rst, input logic i_rdy, input logic i_clr, input logic [31:0] i_npc,
                       input logic i_resp, input logic [31:0] i_raddr, input logic [31:0] i_rinstr,
                       input logic i_dready);
      drive(i_rst, i_rdy, i_clr, i_npc, i_resp, i_raddr, i_rinstr, i_dready);
      compare_model();
   endtask

   task automatic do_reset();
      c_busy = 1'b0; c_cnt = 0; c_addr = 32'h0;
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   // one cycle with the cache responder choosing the response
   task automatic run_cycle(input logic i_rdy, input logic i_clr, input logic [31:0] i_npc,
                            input logic i_dready, input logic corrupt);
      logic        resp;
      logic [31:0] ra, ri;
      resp = 1'b0; ra = 32'h0; ri = 32'h0;
      if (c_busy && c_cnt == 0) begin
         resp   = 1'b1;
         ra     = corrupt ? c_addr + 32'h8 : c_addr;
         ri     = ($urandom_range(0, 3) == 0) ? 32'h0000_0013 : $urandom;
         c_busy = 1'b0;
      end else if (c_busy) begin
         c_cnt--;
      end else if (m_req) begin
         c_busy = 1'b1; c_addr = m_pc; c_cnt = $urandom_range(1, 4);
      end
      step(1'b0, i_rdy, i_clr, i_npc, resp, ra, ri, i_dready);
      if (i_clr) c_busy = 1'b0;
   endtask

   logic [31:0] jal_next;
   logic [31:0] saved_pc;
   int          guard;

   initial begin
      bus.cache_free = 1'b1;
`ifdef FETCH_JAL_PREDECODE_EN
      jal_next = 32'h0000_0028;
`else
      jal_next = 32'h0000_0024;
`endif
      //            rdy  clr  npc      resp raddr    rinstr        dr    e_addr   req  vld  e_pc     e_instr
      tbl.push_back(v(1, 0, 32'h0,    0, 32'h0,    32'h0,        1, 32'h0,    1, 0, 32'h0,    32'h0));
      tbl.push_back(v(1, 0, 32'h0,    1, 32'h8,    32'h13,       1, 32'h0,    1, 0, 32'h0,    32'h0));
      tbl.push_back(v(1, 0, 32'h0,    1, 32'h0,    32'h13,       1, 32'h4,    1, 1, 32'h0,    32'h13));
      tbl.push_back(v(1, 0, 32'h0,    1, 32'h8,    32'h13,       0, 32'h4,    1, 1, 32'h0,    32'h13));
      tbl.push_back(v(1, 0, 32'h0,    1, 32'h4,    32'h00100093, 1, 32'h8,    1, 1, 32'h4,    32'h00100093));
      tbl.push_back(v(1, 0, 32'h0,    0, 32'h0,    32'h0,        1, 32'h8,    1, 0, 32'h0,    32'h0));
      tbl.push_back(v(1, 1, 32'h20,   0, 32'h0,    32'h0,        0, 32'h20,   1, 0, 32'h0,    32'h0));
      tbl.push_back(v(1, 0, 32'h0,    1, 32'h20,   32'h0080006F, 0, jal_next, 1, 1, 32'h20,   32'h0080006F));
      tbl.push_back(v(1, 1, 32'h1000, 1, jal_next, 32'h13,       0, 32'h1000, 1, 0, 32'h0,    32'h0));
      tbl.push_back(v(1, 0, 32'h0,    0, 32'h0,    32'h0,        0, 32'h1000, 1, 0, 32'h0,    32'h0));
      tbl.push_back(v(0, 0, 32'h0,    1, 32'h1000, 32'h13,       0, 32'h1000, 1, 0, 32'h0,    32'h0));
      tbl.push_back(v(1, 0, 32'h0,    1, 32'h1000, 32'h13,       0, 32'h1004, 1, 1, 32'h1000, 32'h13));

      // reset state
      do_reset();
      check("rst_req",   32'(bus.out_fetcher_ready), 32'h0);
      check("rst_addr",  bus.instr_addr, 32'h0);
      check("rst_valid", 32'(bus.dec_valid), 32'h0);
      check("rst_instr", bus.dec_instr, 32'h0);
      check("rst_pc",    bus.dec_pc, 32'h0);

      // directed vector table
      foreach (tbl[i]) begin
         drive(1'b0, tbl[i].rdy, tbl[i].clr, tbl[i].npc, tbl[i].resp, tbl[i].raddr,
               tbl[i].rinstr, tbl[i].dready);
         check($sformatf("tbl%0d_addr", i),  bus.instr_addr, tbl[i].e_addr);
         check($sformatf("tbl%0d_req", i),   32'(bus.out_fetcher_ready), 32'(tbl[i].e_req));
         check($sformatf("tbl%0d_valid", i), 32'(bus.dec_valid), 32'(tbl[i].e_valid));
         check($sformatf("tbl%0d_pc", i),    bus.dec_pc, tbl[i].e_pc);
         check($sformatf("tbl%0d_instr", i), bus.dec_instr, tbl[i].e_instr);
      end

      // decoder stalled: buffer fills to 4, request drops, then drains in order
      do_reset();
      for (int k = 0; k < 40; k++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      check("fill_req",   32'(bus.out_fetcher_ready), 32'h0);
      check("fill_valid", 32'(bus.dec_valid), 32'h1);
      check("fill_addr",  bus.instr_addr, 32'h10);
      for (int k = 0; k < 4; k++) begin
         check("pop_order", bus.dec_pc, 32'(4 * k));
         run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      end
      check("resume_req", 32'(bus.out_fetcher_ready), 32'h1);

      // flush with three buffered entries and a response in the same cycle
      do_reset();
      guard = 0;
      while (mq.size() != 3 && guard < 60) begin
         run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         guard++;
      end
      check("fill3_reached", 32'(mq.size()), 32'd3);
      step(1'b0, 1'b1, 1'b1, 32'h1000, 1'b1, m_pc, 32'h13, 1'b0);
      c_busy = 1'b0;
      check("clr_valid", 32'(bus.dec_valid), 32'h0);
      check("clr_addr",  bus.instr_addr, 32'h1000);
      check("clr_req",   32'(bus.out_fetcher_ready), 32'h1);

      // rdy low for five cycles with a matching response pulse
      saved_pc = m_pc;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 1'b0, 32'h0, (k == 2), saved_pc, 32'h13, 1'b1);
         check("freeze_addr", bus.instr_addr, saved_pc);
      end
      for (int k = 0; k < 10; k++) run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

      // randomized run against the model
      do_reset();
      for (int k = 0; k < 2000; k++) begin
         logic        r_rdy, r_clr, r_dr, r_bad;
         logic [31:0] r_npc;
         r_rdy = ($urandom_range(0, 7) != 0);
         r_clr = ($urandom_range(0, 59) == 0);
         r_dr  = ($urandom_range(0, 2) != 0);
         r_bad = ($urandom_range(0, 7) == 0);
         r_npc = $urandom & 32'hFFFF_FFFC;
         run_cycle(r_rdy, r_clr, r_npc, r_dr, r_bad);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
